// File: rtl/axis_ramp_sequencer_pkg.sv
// Shared types and constants for the AXI4-Stream ramp request sequencer.
package axis_ramp_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int HIGH_LEVEL_DEFAULT = 8191;
  localparam int BURST_WIDTH        = 16;

endpackage : axis_ramp_sequencer_pkg

// File: rtl/ramp_seq_channel.sv
// One request channel: beat counter (optional), duty compare and sample mux.
// With OWN_COUNTER = 0 the channel follows an externally supplied count.
module ramp_seq_channel
  import axis_ramp_sequencer_pkg::*;
#(
  parameter int COUNTER_WIDTH = 18,
  parameter int DATA_WIDTH    = 16,
  parameter int HIGH_LEVEL    = HIGH_LEVEL_DEFAULT,
  parameter bit OWN_COUNTER   = 1'b1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     load_i,
  input  logic                     clear_i,
  input  logic                     advance_i,
  input  logic                     run_i,
  input  logic [COUNTER_WIDTH-1:0] load_val_i,
  input  logic [COUNTER_WIDTH-1:0] period_i,
  input  logic [COUNTER_WIDTH-1:0] duty_i,
  input  logic [COUNTER_WIDTH-1:0] ext_cnt_i,
  output logic [COUNTER_WIDTH-1:0] cnt_o,
  output logic                     rq_o,
  output logic [DATA_WIDTH-1:0]    tdata_o
);

  localparam logic [DATA_WIDTH-1:0] HIGH_WORD = DATA_WIDTH'(HIGH_LEVEL);

  logic [COUNTER_WIDTH-1:0] cnt;

  if (OWN_COUNTER) begin : g_own
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (clear_i) begin
        cnt_d = '0;
      end else if (advance_i) begin
        cnt_d = (cnt_q == period_i) ? '0 : cnt_q + COUNTER_WIDTH'(1);
      end
    end

    // NOTE: state registers use non-blocking assignments so all flops update on the same edge.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt = cnt_q;

    logic unused_ext;
    assign unused_ext = ^ext_cnt_i;
  end else begin : g_shared
    assign cnt = ext_cnt_i;

    logic unused_ctl;
    assign unused_ctl = ^{aclk, aresetn, load_i, clear_i, advance_i, load_val_i, period_i};
  end

  // Request derives from registered state only, so it never glitches with tready.
  assign cnt_o   = cnt;
  assign rq_o    = run_i & (cnt >= duty_i);
  assign tdata_o = rq_o ? HIGH_WORD : '0;

endmodule : ramp_seq_channel

// File: rtl/axis_ramp_sequencer.sv
// Multi-channel ramp request sequencer streaming per-channel levels on AXI4-Stream.
// Optional feature macro RAMP_SEQ_PHASE_EN: per-channel start phase via cfg_phase.
module axis_ramp_sequencer
  import axis_ramp_sequencer_pkg::*;
#(
  parameter int COUNTER_WIDTH = 18,
  parameter int CHANNELS      = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int HIGH_LEVEL    = HIGH_LEVEL_DEFAULT
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [COUNTER_WIDTH-1:0]          cfg_period,
  input  logic [CHANNELS*COUNTER_WIDTH-1:0] cfg_duty,
`ifdef RAMP_SEQ_PHASE_EN
  input  logic [CHANNELS*COUNTER_WIDTH-1:0] cfg_phase,
`else
`endif
  input  logic [BURST_WIDTH-1:0]            cfg_burst,
  input  logic                              start,
  input  logic                              stop,
  output logic                              busy,
  output logic                              done,
  output logic [CHANNELS-1:0]               ramp_rq,
  output logic [CHANNELS*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready
);

  state_e                            state_q, state_d;
  logic [COUNTER_WIDTH-1:0]          period_q;
  logic [CHANNELS*COUNTER_WIDTH-1:0] duty_q;
  logic [BURST_WIDTH-1:0]            burst_q;
  logic [BURST_WIDTH-1:0]            wrap_cnt_q, wrap_cnt_d;
  logic                              tvalid_q;

  logic                              run;
  logic                              advance;
  logic                              load;
  logic                              clear;
  logic                              wrap;
  logic                              burst_hit;
  logic [BURST_WIDTH:0]              wrap_next;
  logic [COUNTER_WIDTH-1:0]          base_cnt;

  assign run       = (state_q == ST_RUN);
  assign advance   = run & tvalid_q & m_axis_tready;
  assign wrap      = advance & (base_cnt == period_q);
  assign wrap_next = {1'b0, wrap_cnt_q} + (BURST_WIDTH + 1)'(1);
  assign burst_hit = (burst_q != '0) && (wrap_next == {1'b0, burst_q});

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (wrap && burst_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Leaving RUN for any reason discards progress; the load on start takes priority.
  assign clear = (state_d != ST_RUN);

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (load || clear) begin
      wrap_cnt_d = '0;
    end else if (wrap && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + BURST_WIDTH'(1);
    end
  end

  // NOTE: shadows are plain datapath registers yet still reset, so outputs are defined from reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      wrap_cnt_q <= '0;
      tvalid_q   <= 1'b0;
      period_q   <= '0;
      duty_q     <= '0;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      wrap_cnt_q <= wrap_cnt_d;
      tvalid_q   <= 1'b1;
      if (load) begin
        period_q <= cfg_period;
        duty_q   <= cfg_duty;
        burst_q  <= cfg_burst;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [COUNTER_WIDTH-1:0] load_val;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic                     rq;
    logic [DATA_WIDTH-1:0]    tdata;

`ifdef RAMP_SEQ_PHASE_EN
    localparam bit OWN = 1'b1;
    logic [COUNTER_WIDTH-1:0] phase;
    assign phase    = cfg_phase[i*COUNTER_WIDTH +: COUNTER_WIDTH];
    assign load_val = (phase > cfg_period) ? cfg_period : phase;
`else
    localparam bit OWN = (i == 0);
    assign load_val = '0;
`endif

    ramp_seq_channel #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .HIGH_LEVEL    (HIGH_LEVEL),
      .OWN_COUNTER   (OWN)
    ) u_channel (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .load_i     (load),
      .clear_i    (clear),
      .advance_i  (advance),
      .run_i      (run),
      .load_val_i (load_val),
      .period_i   (period_q),
      .duty_i     (duty_q[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .ext_cnt_i  (base_cnt),
      .cnt_o      (cnt),
      .rq_o       (rq),
      .tdata_o    (tdata)
    );

    assign ramp_rq[i]                               = rq;
    assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = tdata;
  end

  // Channel 0 owns the reference count: it drives burst wraps and, without phases, all channels.
  assign base_cnt = g_ch[0].cnt;

  assign busy          = run;
  assign done          = (state_q == ST_DONE);
  assign m_axis_tvalid = tvalid_q;

endmodule : axis_ramp_sequencer

// File: tb/tb_axis_ramp_sequencer.sv
// Directed self-checking bench for axis_ramp_sequencer (2 channels, 18-bit counters, 16-bit samples).
module tb_axis_ramp_sequencer;

  localparam int CW = 18;
  localparam int CH = 2;
  localparam int DW = 16;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [CW-1:0]    cfg_period;
  logic [CH*CW-1:0] cfg_duty;
`ifdef RAMP_SEQ_PHASE_EN
  logic [CH*CW-1:0] cfg_phase;
`endif
  logic [15:0]      cfg_burst;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic [CH-1:0]    ramp_rq;
  logic [CH*DW-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;

  int checks = 0;
  int errors = 0;

  axis_ramp_sequencer #(
    .COUNTER_WIDTH (CW),
    .CHANNELS      (CH),
    .DATA_WIDTH    (DW),
    .HIGH_LEVEL    (8191)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
`ifdef RAMP_SEQ_PHASE_EN
    .cfg_phase     (cfg_phase),
`endif
    .cfg_burst     (cfg_burst),
    .start         (start),
    .stop          (stop),
    .busy          (busy),
    .done          (done),
    .ramp_rq       (ramp_rq),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_tdata(input logic [1:0] rq);
    exp_tdata = {rq[1] ? 16'd8191 : 16'd0, rq[0] ? 16'd8191 : 16'd0};
  endfunction

  task automatic check_outs(input string tag, input logic [1:0] rq, input logic b,
                            input logic d, input logic tv);
    check($sformatf("%s rq", tag),     64'(ramp_rq),       64'(rq));
    check($sformatf("%s tdata", tag),  64'(m_axis_tdata),  64'(exp_tdata(rq)));
    check($sformatf("%s busy", tag),   64'(busy),          64'(b));
    check($sformatf("%s done", tag),   64'(done),          64'(d));
    check($sformatf("%s tvalid", tag), 64'(m_axis_tvalid), 64'(tv));
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn       = 1'b0;
    cfg_period    = '0;
    cfg_duty      = '0;
    cfg_burst     = '0;
    start         = 1'b0;
    stop          = 1'b0;
    m_axis_tready = 1'b1;
`ifdef RAMP_SEQ_PHASE_EN
    cfg_phase     = '0;
`endif

    // Reset state, then tvalid on the first edge after release.
    #12;
    check_outs("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b1;
    tick();
    check_outs("post_reset", 2'b00, 1'b0, 1'b0, 1'b1);

    // Continuous run, period 9; ch0 duty 5, ch1 duty 7; cfg change after start must not apply.
    cfg_period = 18'd9;
    cfg_duty   = {18'd7, 18'd5};
    cfg_burst  = 16'd0;
    pulse_start();
    cfg_period = 18'd3;
    for (int k = 0; k < 20; k++) begin
      check_outs($sformatf("cont b%0d", k), {(k % 10) >= 7, (k % 10) >= 5}, 1'b1, 1'b0, 1'b1);
      tick();
    end
    pulse_stop();
    check_outs("cont stopped", 2'b00, 1'b0, 1'b0, 1'b1);

    // Same pattern with tready toggling: beats advance only every other cycle.
    cfg_period = 18'd9;
    pulse_start();
    begin
      int k;
      k = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        check_outs($sformatf("toggle c%0d", cyc), {(k % 10) >= 7, (k % 10) >= 5}, 1'b1, 1'b0, 1'b1);
        m_axis_tready = ((cyc % 2) == 0);
        tick();
        if ((cyc % 2) == 0) k++;
      end
    end
    m_axis_tready = 1'b1;
    pulse_stop();

    // Burst of 2 periods of 4 beats; ch1 duty 0 is always high; a start mid-run is ignored.
    cfg_period = 18'd3;
    cfg_duty   = {18'd0, 18'd2};
    cfg_burst  = 16'd2;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      check_outs($sformatf("burst b%0d", k), {1'b1, (k % 4) >= 2}, 1'b1, 1'b0, 1'b1);
      if (k == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check_outs("burst done", 2'b00, 1'b0, 1'b1, 1'b1);
    tick();
    check_outs("burst idle", 2'b00, 1'b0, 1'b0, 1'b1);

    // Period 0: wrap every beat; duty 0 always high, duty 1 never high; burst 3.
    cfg_period = 18'd0;
    cfg_duty   = {18'd0, 18'd1};
    cfg_burst  = 16'd3;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      check_outs($sformatf("p0 b%0d", k), 2'b10, 1'b1, 1'b0, 1'b1);
      tick();
    end
    check_outs("p0 done", 2'b00, 1'b0, 1'b1, 1'b1);
    tick();
    check_outs("p0 idle", 2'b00, 1'b0, 1'b0, 1'b1);

    // Stop together with start on beat 4: stop wins, no done.
    cfg_period = 18'd9;
    cfg_duty   = {18'd0, 18'd2};
    cfg_burst  = 16'd0;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      check_outs($sformatf("stop b%0d", k), {1'b1, k >= 2}, 1'b1, 1'b0, 1'b1);
      tick();
    end
    check_outs("stop b4", 2'b11, 1'b1, 1'b0, 1'b1);
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    check_outs("stop idle", 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("stop stays idle", 2'b00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run.
    pulse_start();
    tick();
    tick();
    tick();
    check_outs("prereset run", 2'b11, 1'b1, 1'b0, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check_outs("async reset", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("held reset", 2'b00, 1'b0, 1'b0, 1'b0);
    aresetn = 1'b1;
    tick();
    check_outs("reset release", 2'b00, 1'b0, 1'b0, 1'b1);

`ifdef RAMP_SEQ_PHASE_EN
    // Phase offsets: channel 1 starts 4 counts ahead of channel 0.
    cfg_period = 18'd7;
    cfg_duty   = {18'd4, 18'd4};
    cfg_phase  = {18'd4, 18'd0};
    cfg_burst  = 16'd0;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      check_outs($sformatf("phase b%0d", k), {((k + 4) % 8) >= 4, (k % 8) >= 4}, 1'b1, 1'b0, 1'b1);
      tick();
    end
    pulse_stop();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_axis_ramp_sequencer
